mt_stream_reader: RTL and testbench

- Consumer end of the MTwister extraction interface (trig/ready/last/r_num).
- Pulls tempered words on demand, buffers them in a small FIFO and presents them as a valid/ready stream to downstream logic.
- Hides the generator's regeneration gap (ready low after the last word of a block) and checks block framing.
- Sits between the MTwister instance and any PRNG-consuming datapath.

---
 rtl/mt_stream_reader.sv | 131 +++++++++++++
 tb/tb_mt_stream_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mt_stream_reader.sv
// Consumer side of the MTwister extraction interface: issues credit-limited word
// requests, buffers landed words in a FIFO and presents them as a valid/ready stream.
//
// state    | meaning
// S_WAIT   | generator not in extraction; requests allowed once ready rises
// S_STREAM | generator extracting; requests flow under the FIFO credit limit
// S_REGEN  | last word of a block requested; hold off until ready returns
module mt_stream_reader #(
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 1,
  parameter int N      = 624
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mt_ready,
  input  logic                     mt_last,
  input  logic [31:0]              mt_r_num,
  output logic                     mt_trig,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [31:0]              m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int OW = LW + $clog2(RD_LAT + 1);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_WAIT, S_STREAM, S_REGEN} state_t;

  state_t            state, state_nxt;
  logic [RD_LAT-1:0] pipe;
  logic [OW-1:0]     inflight, occ;
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0]     level_after_pop, level_nxt;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       head_nxt;
  logic [CW-1:0]     cnt;
  logic              push, pop;

  // Credit covers stored words plus words already requested but not yet landed.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OW'(pipe[i]);
    occ = OW'(level) + inflight;
  end

  assign mt_trig = rst_n && en && mt_ready && (state != S_REGEN) && (occ < OW'(DEPTH));
  assign push    = pipe[RD_LAT-1];
  assign m_valid = (level != '0);
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= mt_trig;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT: begin
        if (mt_trig && mt_last) state_nxt = S_REGEN;
        else if (mt_ready)      state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (mt_trig && mt_last) state_nxt = S_REGEN;
        else if (!mt_ready)     state_nxt = S_WAIT;
      end
      S_REGEN: begin
        if (mt_ready) state_nxt = S_STREAM;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Next head word: the landing word when the FIFO would otherwise be empty.
  always_comb begin
    level_after_pop = pop ? (level - LW'(1)) : level;
    level_nxt       = level_after_pop + LW'(push);
    rd_nxt          = pop ? (rd_ptr + AW'(1)) : rd_ptr;
    head_nxt        = (level_after_pop == '0) ? mt_r_num : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mt_r_num;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      m_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      level  <= level_nxt;
      if (level_nxt != '0) m_data <= head_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (mt_trig) begin
      if (mt_last) begin
        cnt <= '0;
        if (cnt != CW'(N - 1)) err <= 1'b1;
      end else if (cnt == CW'(N - 1)) begin
        cnt <= '0;
        err <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mt_stream_reader.sv
// Directed + randomized bench for mt_stream_reader against a small generator model
// with short blocks; the stream must equal the generator's word sequence in order.
module tb_mt_stream_reader;

  localparam int DEPTH  = 8;
  localparam int RD_LAT = 1;
  localparam int NBLK   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        m_ready = 1'b1;
  logic        mt_ready, mt_last, mt_trig, m_valid, err;
  logic [31:0] mt_r_num = '0;
  logic [31:0] m_data;
  logic [3:0]  level;

  mt_stream_reader #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .N(NBLK)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mt_ready(mt_ready), .mt_last(mt_last),
    .mt_r_num(mt_r_num), .mt_trig(mt_trig), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .level(level), .err(err)
  );

  always #5 clk = ~clk;

  // Generator model: one word per request, ready drops for gap_len cycles after a block.
  int          gen_idx = 0;
  int          gen_gap = 0;
  int          gap_len = 10;
  logic        gen_ready = 1'b0;
  logic [31:0] gen_next = 32'd1;
  logic        bad_req = 1'b0;
  logic        bad_done = 1'b0;
  logic        bad_active;

  assign bad_active = bad_req && !bad_done;
  assign mt_ready   = gen_ready;
  assign mt_last    = gen_ready && (gen_idx == (bad_active ? 2 : NBLK - 1));

  always @(posedge clk) begin
    if (!rst_n) begin
      gen_idx   <= 0;
      gen_ready <= 1'b1;
      gen_gap   <= 0;
    end else if (mt_trig) begin
      mt_r_num <= gen_next;
      gen_next <= gen_next + 32'd1;
      if (mt_last) begin
        gen_idx   <= 0;
        gen_ready <= 1'b0;
        gen_gap   <= gap_len;
        if (bad_active) bad_done <= 1'b1;
      end else begin
        gen_idx <= gen_idx + 1;
      end
    end else if (!gen_ready) begin
      if (gen_gap <= 1) gen_ready <= 1'b1;
      gen_gap <= gen_gap - 1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          trig_cnt = 0;
  int          blk_cnt = 0;
  logic [31:0] exp_next = 32'd1;
  logic        last_bad_trig = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sample just after inputs settle (well before the next posedge), then advance a cycle.
  task automatic cyc();
    #1;
    if (m_valid && m_ready) begin
      chk("data", m_data, exp_next);
      exp_next++;
    end
    if (mt_trig) begin
      trig_cnt++;
      chk("trig_when_ready", {31'b0, mt_ready}, 32'd1);
      if (mt_last) begin
        if (!bad_active) chk("block_len", blk_cnt + 1, NBLK);
        blk_cnt = 0;
      end else begin
        blk_cnt++;
      end
    end
    if (!en) chk("en_blocks_trig", {31'b0, mt_trig}, 32'd0);
    chk("level_bound", {31'b0, level <= 4'(DEPTH)}, 32'd1);
    last_bad_trig = mt_trig && mt_last && bad_active;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    exp_next = gen_next;
    blk_cnt  = 0;
    trig_cnt = 0;
  endtask

  task automatic wait_words(input int n, input int budget, input bit rnd);
    logic [31:0] target;
    target = exp_next + n;
    for (int i = 0; i < budget && exp_next < target; i++) begin
      if (rnd) begin
        m_ready = ($urandom % 4) != 0;
        en      = ($urandom % 8) != 0;
      end
      cyc();
    end
    en = 1'b1;
    chk("words_delivered", {31'b0, exp_next >= target}, 32'd1);
  endtask

  initial begin
    // Reset values and first-word latency
    repeat (3) @(negedge clk);
    #1;
    chk("rst_trig", {31'b0, mt_trig}, 32'd0);
    chk("rst_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_level", {28'b0, level}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    exp_next = gen_next;
    rst_n = 1'b1;
    #1;
    chk("first_trig", {31'b0, mt_trig}, 32'd1);
    chk("first_valid_c0", {31'b0, m_valid}, 32'd0);
    cyc();
    chk("first_valid_c1", {31'b0, m_valid}, 32'd0);
    cyc();
    chk("first_valid_c2", {31'b0, m_valid}, 32'd1);
    chk("first_data", m_data, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stream_cont", {31'b0, m_valid}, 32'd1);
    end
    wait_words(95, 1000, 1'b0);
    chk("t1_err", {31'b0, err}, 32'd0);

    // Credit limit with stalled downstream
    m_ready = 1'b0;
    do_reset();
    repeat (40) cyc();
    chk("fill_trigs", trig_cnt, 32'd8);
    chk("fill_level", {28'b0, level}, 32'd8);
    chk("fill_no_trig", {31'b0, mt_trig}, 32'd0);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    repeat (5) cyc();
    chk("one_pop_trigs", trig_cnt, 32'd9);
    chk("one_pop_level", {28'b0, level}, 32'd8);

    // Randomized backpressure and enable across regeneration gaps
    m_ready = 1'b1;
    wait_words(100, 3000, 1'b1);
    chk("t3_err", {31'b0, err}, 32'd0);

    // Framing error: last asserted on the third word of a block
    m_ready = 1'b1;
    for (int i = 0; i < 100 && mt_ready; i++) cyc();
    bad_req = 1'b1;
    chk("t4_err_before", {31'b0, err}, 32'd0);
    for (int i = 0; i < 100 && !last_bad_trig; i++) cyc();
    chk("t4_bad_seen", {31'b0, last_bad_trig}, 32'd1);
    chk("t4_err_set", {31'b0, err}, 32'd1);
    wait_words(40, 1000, 1'b1);
    chk("t4_err_sticky", {31'b0, err}, 32'd1);

    // Full FIFO with push and pop together
    gap_len = int'($urandom_range(1, 3));
    m_ready = 1'b0;
    for (int i = 0; i < 100 && level != 4'd8; i++) cyc();
    chk("t5_full", {28'b0, level}, 32'd8);
    m_ready = 1'b1;
    wait_words(200, 2000, 1'b0);
    chk("t5_err_sticky", {31'b0, err}, 32'd1);

    // Async reset mid-stream: 3 stored, 1 in flight
    gap_len = 10;
    m_ready = 1'b0;
    do_reset();
    chk("t6_err_cleared", {31'b0, err}, 32'd0);
    for (int i = 0; i < 50 && level != 4'd3; i++) cyc();
    chk("t6_level3", {28'b0, level}, 32'd3);
    chk("t6_trigs", trig_cnt, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("t6_trig0", {31'b0, mt_trig}, 32'd0);
    chk("t6_valid0", {31'b0, m_valid}, 32'd0);
    chk("t6_data0", m_data, 32'd0);
    chk("t6_level0", {28'b0, level}, 32'd0);
    chk("t6_err0", {31'b0, err}, 32'd0);
    @(negedge clk);
    m_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && !m_valid; i++) cyc();
    chk("t6_fresh_word", m_data, exp_next);
    wait_words(20, 500, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
